id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It captures decoded operands, register indices and control bits from ID each cycle, and supplies `id_ex_rs`/`id_ex_rt` and the EX-side controls consumed by the EX-stage forwarding unit and ALU. It detects load-use hazards that forwarding cannot cover, inserts one bubble, and stalls PC and IF/ID. It also honours branch flush and whole-pipeline memory freeze.

---
 rtl/mips_pipe_pkg.sv | 14 +
 rtl/load_use_detect.sv | 15 +
 rtl/id_ex_stage.sv | 77 +++++++
 tb/tb_id_ex_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: control-bundle layout and shared constants for the 5-stage MIPS pipeline.
package mips_pipe_pkg;
    localparam int CTRL_W        = 9;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP    = 0;
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX has not yet produced.
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  logic       id_ex_memRead,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       uses_rs,
    input  logic       uses_rt,
    output logic       lu_hazard
);
    assign lu_hazard = id_ex_memRead && (id_ex_rt != REG_ZERO) &&
                       ((uses_rs && id_ex_rt == if_id_rs) || (uses_rt && id_ex_rt == if_id_rt));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, branch flush and memory freeze.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        if_id_rs,
    input  logic [4:0]        if_id_rt,
    input  logic [4:0]        if_id_rd,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DW-1:0]     rs_data,
    input  logic [DW-1:0]     rt_data,
    input  logic [DW-1:0]     imm_ext,
    input  logic [DW-1:0]     pc_plus4,
    input  logic              flush,
    input  logic              mem_busy,
    output logic [4:0]        id_ex_rs,
    output logic [4:0]        id_ex_rt,
    output logic [4:0]        id_ex_rd,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic [DW-1:0]     id_ex_rs_data,
    output logic [DW-1:0]     id_ex_rt_data,
    output logic [DW-1:0]     id_ex_imm,
    output logic [DW-1:0]     id_ex_pc4,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  stall_count
);
    logic lu_hazard;
    logic bubble;
    logic stall_inc;

    load_use_detect u_lud (
        .id_ex_memRead(id_ex_ctrl[CTRL_MEMREAD]),
        .id_ex_rt     (id_ex_rt),
        .if_id_rs     (if_id_rs),
        .if_id_rt     (if_id_rt),
        .uses_rs      (uses_rs),
        .uses_rt      (uses_rt),
        .lu_hazard    (lu_hazard)
    );

    // A flush kills the dependent instruction, so it overrides the stall.
    assign bubble      = flush | lu_hazard;
    assign stall_inc   = lu_hazard & ~flush & ~&stall_count;
    assign pc_write    = ~(mem_busy | (lu_hazard & ~flush));
    assign if_id_write = pc_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_rs      <= REG_ZERO;
            id_ex_rt      <= REG_ZERO;
            id_ex_rd      <= REG_ZERO;
            id_ex_ctrl    <= CTRL_NOP;
            id_ex_rs_data <= '0;
            id_ex_rt_data <= '0;
            id_ex_imm     <= '0;
            id_ex_pc4     <= '0;
            stall_count   <= '0;
        end else if (!mem_busy) begin
            id_ex_rs      <= bubble ? REG_ZERO : if_id_rs;
            id_ex_rt      <= bubble ? REG_ZERO : if_id_rt;
            id_ex_rd      <= bubble ? REG_ZERO : if_id_rd;
            id_ex_ctrl    <= bubble ? CTRL_NOP : ctrl_in;
            id_ex_rs_data <= bubble ? '0 : rs_data;
            id_ex_rt_data <= bubble ? '0 : rt_data;
            id_ex_imm     <= bubble ? '0 : imm_ext;
            id_ex_pc4     <= bubble ? '0 : pc_plus4;
            stall_count   <= stall_count + CNT_W'(stall_inc);
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench comparing id_ex_stage against a pipeline-level reference model.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic [4:0]    rs, rt, rd;
        logic [8:0]    ctrl;
        logic [DW-1:0] a, b, imm, pc4;
        logic [CW-1:0] cnt;
    } st_t;

    typedef struct packed {
        st_t  st;
        logic pw;
    } rec_t;

    logic clk = 0, rst = 1;
    logic [4:0] if_id_rs = 0, if_id_rt = 0, if_id_rd = 0;
    logic uses_rs = 0, uses_rt = 0, flush = 0, mem_busy = 0;
    logic [8:0] ctrl_in = 0;
    logic [DW-1:0] rs_data = 0, rt_data = 0, imm_ext = 0, pc_plus4 = 0;
    logic [4:0] id_ex_rs, id_ex_rt, id_ex_rd;
    logic [8:0] id_ex_ctrl;
    logic [DW-1:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc4;
    logic pc_write, if_id_write;
    logic [CW-1:0] stall_count;

    id_ex_stage #(.DW(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rd(if_id_rd),
        .uses_rs(uses_rs), .uses_rt(uses_rt), .ctrl_in(ctrl_in),
        .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .pc_plus4(pc_plus4),
        .flush(flush), .mem_busy(mem_busy),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_ctrl(id_ex_ctrl),
        .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
        .id_ex_imm(id_ex_imm), .id_ex_pc4(id_ex_pc4),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] C_ADD  = 9'h10A;
    localparam logic [8:0] C_LW   = 9'h1B0;
    localparam logic [8:0] C_ADDI = 9'h110;

    int checks = 0, failures = 0, cyc = 0;
    rec_t q[$];
    st_t model = '0;
    bit stim_done = 0;

    function automatic st_t dut_state();
        return '{id_ex_rs, id_ex_rt, id_ex_rd, id_ex_ctrl, id_ex_rs_data, id_ex_rt_data,
                 id_ex_imm, id_ex_pc4, stall_count};
    endfunction

    // One ID cycle: drive inputs after the edge, predict this cycle's stall outputs and the next register contents.
    task automatic step(input logic [4:0] rs, rt, rd, input logic urs, urt,
                        input logic [8:0] ctrl, input logic fl, busy);
        logic hz;
        st_t nxt;
        @(posedge clk);
        #2;
        rst = 0;
        if_id_rs = rs; if_id_rt = rt; if_id_rd = rd; uses_rs = urs; uses_rt = urt;
        ctrl_in = ctrl; flush = fl; mem_busy = busy;
        rs_data = $urandom; rt_data = $urandom; imm_ext = $urandom; pc_plus4 = $urandom & ~32'h3;
        hz = model.ctrl[7] && model.rt != 0 &&
             ((urs && model.rt == rs) || (urt && model.rt == rt));
        q.push_back('{model, !(busy || (hz && !fl))});
        nxt = model;
        if (!busy) begin
            if (fl || hz) begin
                nxt = '0;
                nxt.cnt = model.cnt;
                if (hz && !fl && model.cnt != {CW{1'b1}}) nxt.cnt = model.cnt + 1'b1;
            end else begin
                nxt = '{rs, rt, rd, ctrl, rs_data, rt_data, imm_ext, pc_plus4, model.cnt};
            end
        end
        model = nxt;
    endtask

    // Reset raised in the middle of a cycle while a load-use stall is pending.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        if_id_rs = model.rt; uses_rs = 1; flush = 0; mem_busy = 0;
        #1 rst = 1;
        #1;
        checks++;
        if (dut_state() !== '0 || pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got rs=%0d rt=%0d ctrl=%h cnt=%0d pw=%b iw=%b required all-zero pw=1 iw=1",
                     id_ex_rs, id_ex_rt, id_ex_ctrl, stall_count, pc_write, if_id_write);
        end
        model = '0;
        q.push_back('{model, 1'b1});
    endtask

    initial begin : monitor
        rec_t r;
        st_t g;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                r = q.pop_front();
                g = dut_state();
                cyc++;
                checks += 3;
                if (g !== r.st) begin
                    failures++;
                    $display("FAIL regs cyc=%0d got rs=%0d rt=%0d rd=%0d ctrl=%h a=%h b=%h imm=%h pc4=%h cnt=%0d required rs=%0d rt=%0d rd=%0d ctrl=%h a=%h b=%h imm=%h pc4=%h cnt=%0d",
                             cyc, g.rs, g.rt, g.rd, g.ctrl, g.a, g.b, g.imm, g.pc4, g.cnt,
                             r.st.rs, r.st.rt, r.st.rd, r.st.ctrl, r.st.a, r.st.b, r.st.imm, r.st.pc4, r.st.cnt);
                end
                if (pc_write !== r.pw) begin
                    failures++;
                    $display("FAIL pc_write cyc=%0d got=%b required=%b", cyc, pc_write, r.pw);
                end
                if (if_id_write !== r.pw) begin
                    failures++;
                    $display("FAIL if_id_write cyc=%0d got=%b required=%b", cyc, if_id_write, r.pw);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        repeat (2) @(posedge clk);
        // add $3,$1,$2 after reset
        step(1, 2, 3, 1, 1, C_ADD, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // lw $5 then dependent add $6,$5,$2: one bubble, then the add
        step(1, 5, 0, 1, 0, C_LW, 0, 0);
        step(5, 2, 6, 1, 1, C_ADD, 0, 0);
        step(5, 2, 6, 1, 1, C_ADD, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // lw $0 never stalls; addi with unused rt field matching never stalls
        step(1, 0, 0, 1, 0, C_LW, 0, 0);
        step(0, 2, 6, 1, 1, C_ADD, 0, 0);
        step(1, 5, 0, 1, 0, C_LW, 0, 0);
        step(4, 5, 7, 1, 0, C_ADDI, 0, 0);
        // hazard coincident with flush: bubble, no stall, no count
        step(1, 5, 0, 1, 0, C_LW, 0, 0);
        step(5, 2, 6, 1, 1, C_ADD, 1, 0);
        // freeze with a hazard pending and flush pulsed, then release
        step(1, 5, 0, 1, 0, C_LW, 0, 0);
        step(5, 2, 6, 1, 1, C_ADD, 0, 1);
        step(5, 2, 6, 1, 1, C_ADD, 1, 1);
        step(5, 2, 6, 1, 1, C_ADD, 0, 1);
        step(5, 2, 6, 1, 1, C_ADD, 0, 0);
        step(5, 2, 6, 1, 1, C_ADD, 0, 0);
        // drive the counter into saturation with back-to-back dependent loads
        for (int i = 0; i < 20; i++) begin
            step(1, 5, 0, 1, 0, C_LW, 0, 0);
            step(5, 5, 0, 1, 0, C_LW, 0, 0);
        end
        step(1, 5, 0, 1, 0, C_LW, 0, 0);
        mid_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [8:0] c;
            c = 9'($urandom);
            c[7] = ($urandom_range(0, 1) == 0);
            if (i == 700) mid_reset();
            step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                 1'($urandom), 1'($urandom), c,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        end
        stim_done = 1;
        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
